ifetch_stage: RTL and testbench



---
 rtl/ifetch_stage.sv | 113 +++++++++++
 tb/tb_ifetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding word
// reads to instruction memory and queues returned words with their PCs for decode.
module ifetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_pc;
    logic             r_outstanding;
    logic             r_discard;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_pc    [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_after;
    logic [31:0]      w_redir_pc;

    // Handshake decode and the request rule; a request is only made when the
    // queue is guaranteed to have room for its response.
    always_comb begin
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_count_after = r_count;
        imem_req      = 1'b0;
        w_redir_pc    = redirect_pc & 32'hFFFF_FFFC;

        w_push        = imem_ack && r_outstanding && !r_discard && !redirect;
        w_pop         = (r_count != '0) && id_ready && !redirect;
        w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        imem_req      = reset && !redirect && (!r_outstanding || imem_ack)
                        && (w_count_after < CNT_W'(DEPTH));
    end

    assign imem_addr  = r_fetch_pc;
    assign if_valid   = (r_count != '0);
    assign if_instr   = r_instr[r_rd];
    assign if_pc      = r_pc[r_rd];
    assign if_pcplus4 = r_pc[r_rd] + 32'd4;

    // Fetch PC, outstanding/discard tracking and queue pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
        end else begin
            if (imem_req) begin
                r_outstanding <= 1'b1;
            end else if (imem_ack) begin
                r_outstanding <= 1'b0;
            end

            if (redirect) begin
                // A response still in flight belongs to the old stream.
                r_discard  <= r_outstanding && !imem_ack;
                r_fetch_pc <= w_redir_pc;
                r_rd       <= '0;
                r_wr       <= '0;
                r_count    <= '0;
            end else begin
                if (imem_ack) begin
                    r_discard <= 1'b0;
                end
                if (imem_req) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_req_pc   <= r_fetch_pc;
                end
                if (w_push) begin
                    r_wr <= r_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                r_count <= w_count_after;
            end
        end
    end

    // Queue storage needs no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr] <= imem_rdata;
            r_pc[r_wr]    <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomised and directed bench for ifetch_stage: a transaction-level model predicts
// every request and the ordered (pc, instr) stream decode should see.
module tb_ifetch_stage;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    ifetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pcplus4 (if_pcplus4),
        .id_ready   (id_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
        int unsigned gen;
    } mem_ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    mem_ent_t    mem_q[$];
    fetch_ent_t  exp_q[$];
    mem_ent_t    ack_ent;
    int unsigned cyc       = 0;
    int unsigned epoch     = 0;
    int unsigned gen       = 0;
    int unsigned lat_cfg   = 1;
    bit          rand_lat  = 1'b0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          last_req  = 1'b0;
    logic [31:0] last_addr = '0;
    int unsigned req_cnt   = 0;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd100;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Instruction memory: in-order responses after a per-request latency.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ack_ent    = mem_q.pop_front();
            imem_ack   = 1'b1;
            imem_rdata = mem_word(ack_ent.addr);
        end
    end

    // Monitor and reference model, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin
        bit          acc;
        bit          mpop;
        bit          exp_req;
        int unsigned pend;
        int          sz_after;
        if (!reset) begin
            chk(imem_req == 1'b0, "req_in_reset", 32'(imem_req), 32'd0);
            chk(if_valid == 1'b0, "valid_in_reset", 32'(if_valid), 32'd0);
            exp_q.delete();
            epoch++;
            gen++;
            exp_fetch = RESET_PC;
            last_req  = 1'b0;
            req_cnt   = 0;
        end else begin
            acc  = imem_ack && (ack_ent.epoch == epoch) && (ack_ent.gen == gen) && !redirect;
            mpop = (exp_q.size() != 0) && id_ready && !redirect;

            chk(if_valid == (exp_q.size() != 0), "if_valid", 32'(if_valid),
                32'(exp_q.size() != 0));
            if (if_valid && exp_q.size() != 0) begin
                chk(if_pc == exp_q[0].pc, "if_pc", if_pc, exp_q[0].pc);
                chk(if_instr == exp_q[0].instr, "if_instr", if_instr, exp_q[0].instr);
                chk(if_pcplus4 == exp_q[0].pc + 32'd4, "if_pcplus4", if_pcplus4,
                    exp_q[0].pc + 32'd4);
            end

            pend = 0;
            foreach (mem_q[i]) if (mem_q[i].gen == gen) pend++;
            sz_after = exp_q.size() + int'(acc) - int'(mpop);
            exp_req  = !redirect && (pend == 0) && (sz_after < int'(DEPTH));
            chk(imem_req == exp_req, "imem_req", 32'(imem_req), 32'(exp_req));

            last_req  = imem_req;
            last_addr = imem_addr;
            if (imem_req) begin
                mem_ent_t e;
                chk(imem_addr == exp_fetch, "imem_addr", imem_addr, exp_fetch);
                if (rand_lat) lat_cfg = $urandom_range(1, 4);
                e.addr  = imem_addr;
                e.due   = cyc + lat_cfg;
                e.epoch = epoch;
                e.gen   = gen;
                mem_q.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
                req_cnt++;
            end

            if (mpop) void'(exp_q.pop_front());
            if (acc) begin
                fetch_ent_t f;
                f.pc    = ack_ent.addr;
                f.instr = mem_word(ack_ent.addr);
                exp_q.push_back(f);
            end
            if (redirect) begin
                exp_q.delete();
                epoch++;
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    task automatic wait_req(input bit any, input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (last_req && (any || last_addr == a)) found = 1'b1;
        end
        chk(found, "wait_req_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;

        // Streaming with single-cycle memory.
        repeat (3) step();
        reset = 1'b1;
        repeat (14) step();

        // Decode stalled from reset: queue fills, then drains in order.
        id_ready = 1'b0;
        do_reset(2);
        repeat (10) step();
        chk(req_cnt == 4, "stall_req_count", 32'(req_cnt), 32'd4);
        chk(if_valid == 1'b1, "stall_valid", 32'(if_valid), 32'd1);
        id_ready = 1'b1;
        repeat (12) step();

        // Redirect while the request for 0x8 is in flight.
        lat_cfg = 3;
        do_reset(2);
        wait_req(1'b0, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        step();
        redirect = 1'b0;
        repeat (20) step();

        // Redirect coinciding with an ack and a pending pop.
        lat_cfg = 1;
        do_reset(2);
        repeat (6) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        repeat (8) step();

        // Reset mid-stream with a request outstanding; its ack lands after release.
        lat_cfg = 3;
        do_reset(1);
        wait_req(1'b1, 32'h0);
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (15) step();

        // Fetch across the top of the address space.
        lat_cfg = 1;
        do_reset(1);
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        repeat (8) step();

        // Random traffic: variable latency, back-pressure and redirects.
        rand_lat = 1'b1;
        repeat (3000) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            step();
        end
        redirect = 1'b0;
        id_ready = 1'b1;
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
